// File: rtl/instr_mem_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
// Shared types and constants for the instruction memory loader.
//   load_state_e : loader FSM states (IDLE, LOAD, RUN)
//   NOP_WORD     : word returned for fetches outside the loaded program
//   WORD_BYTES   : bytes per instruction word
//   insertByte   : places a byte into a big-endian lane of a word
// ---------------------------------------------------------------------------
package instr_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } load_state_e;

   localparam logic [31:0] NOP_WORD   = 32'h0;
   localparam int          WORD_BYTES = 4;

   // Lane 0 is the most significant byte, so the first byte streamed in
   // lands in [31:24] and the fourth in [7:0].
   function automatic logic [31:0] insertByte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
      logic [31:0] result;
      result = word;
      result[8*(WORD_BYTES-1-int'(lane)) +: 8] = data;
      return result;
   endfunction

endpackage

// File: rtl/instr_ram.sv
// ---------------------------------------------------------------------------
// instr_ram
// DEPTH x 32 synchronous RAM, one write port and one registered read port.
// Contents are not reset.
//   i_clock  : rising-edge clock
//   i_wrEn   : write enable
//   i_wrAddr : write word address
//   i_wrData : write data
//   i_rdAddr : read word address, sampled every rising edge
//   o_rdData : read data, valid one cycle after i_rdAddr
// ---------------------------------------------------------------------------
module instr_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clock,
   input  logic          i_wrEn,
   input  logic [AW-1:0] i_wrAddr,
   input  logic [31:0]   i_wrData,
   input  logic [AW-1:0] i_rdAddr,
   output logic [31:0]   o_rdData
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdData;

   // Plain RAM template: write and registered read share the clock so the
   // array maps onto block memory.
   always_ff @(posedge i_clock) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
      r_rdData <= r_mem[i_rdAddr];
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/instr_rom_loader.sv
// ---------------------------------------------------------------------------
// instr_rom_loader
// Instruction memory for the processor fetch port, filled over a byte-serial
// valid/ready load port. Fetches return stored words up to the loaded
// length and NOP beyond it; ProgEnd marks the first word past the program.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_loadStart      : in RUN, abandon the program and go back to IDLE
//   i_loadValid      : load byte valid
//   i_loadData       : load byte, big-endian within each word
//   i_loadLast       : final byte of the program
//   o_loadReady      : a byte is accepted this cycle when valid
//   o_loadDone       : high while in RUN
//   o_loadOvf        : sticky, more than DEPTH words were streamed
//   o_progLen        : number of words loaded
//   i_instrAddr      : fetch byte address
//   o_instrData      : fetched word, one cycle after the address
//   o_progEnd        : fetched word index equals o_progLen (in RUN)
//   o_addrErr        : fetch address was not word aligned
// ---------------------------------------------------------------------------
module instr_rom_loader
   import instr_mem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_loadStart,
   input  logic              i_loadValid,
   input  logic [7:0]        i_loadData,
   input  logic              i_loadLast,
   output logic              o_loadReady,
   output logic              o_loadDone,
   output logic              o_loadOvf,
   output logic [CNT_W-1:0]  o_progLen,
   input  logic [ADDR_W-1:0] i_instrAddr,
   output logic [31:0]       o_instrData,
   output logic              o_progEnd,
   output logic              o_addrErr
);

   localparam int AW    = $clog2(DEPTH);
   localparam int IDX_W = ADDR_W - 2;
   localparam int CMP_W = (IDX_W > CNT_W) ? IDX_W : CNT_W;

   load_state_e      r_state;
   load_state_e      w_nextState;
   logic [CNT_W-1:0] r_progLen;
   logic [1:0]       r_byteCnt;
   logic [31:0]      r_word;
   logic             r_loadOvf;
   logic             r_fetchHit;
   logic             r_progEnd;
   logic             r_addrErr;

   logic             w_loadReady;
   logic             w_loadDone;
   logic             w_accept;
   logic             w_full;
   logic             w_wordDone;
   logic             w_wrEn;
   logic [31:0]      w_wordNext;
   logic [31:0]      w_ramData;
   logic [IDX_W-1:0] w_idx;
   logic [CMP_W-1:0] w_idxExt;
   logic [CMP_W-1:0] w_lenExt;

   assign w_accept   = i_loadValid && w_loadReady;
   assign w_full     = (r_progLen == CNT_W'(DEPTH));
   assign w_wordDone = (r_byteCnt == 2'd3) || i_loadLast;
   assign w_wrEn     = w_accept && !w_full && w_wordDone;

   // Starting each word from zero gives the zero padding of unfilled lower
   // lanes for free when the program ends mid-word.
   assign w_wordNext = insertByte((r_byteCnt == 2'd0) ? NOP_WORD : r_word,
                                  r_byteCnt, i_loadData);

   assign w_idx    = i_instrAddr[ADDR_W-1:2];
   assign w_idxExt = CMP_W'(w_idx);
   assign w_lenExt = CMP_W'(r_progLen);

   // Loader state register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake outputs. A byte accepted while the memory is
   // already full is the overflow byte; it ends the load just like LoadLast.
   always_comb begin
      w_nextState = r_state;
      w_loadReady = 1'b1;
      w_loadDone  = 1'b0;
      case (r_state)
         IDLE, LOAD: begin
            if (w_accept) begin
               w_nextState = (w_full || i_loadLast) ? RUN : LOAD;
            end
         end
         RUN: begin
            w_loadReady = 1'b0;
            w_loadDone  = 1'b1;
            if (i_loadStart) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Byte assembly, program length and overflow tracking. LoadStart only
   // matters in RUN, where no byte can be accepted, so it never races a write.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_progLen <= '0;
         r_byteCnt <= 2'd0;
         r_word    <= NOP_WORD;
         r_loadOvf <= 1'b0;
      end else if ((r_state == RUN) && i_loadStart) begin
         r_progLen <= '0;
         r_byteCnt <= 2'd0;
         r_word    <= NOP_WORD;
         r_loadOvf <= 1'b0;
      end else if (w_accept) begin
         if (w_full) begin
            r_loadOvf <= 1'b1;
         end else begin
            r_word <= w_wordNext;
            if (w_wordDone) begin
               r_progLen <= r_progLen + CNT_W'(1);
               r_byteCnt <= 2'd0;
            end else begin
               r_byteCnt <= r_byteCnt + 2'd1;
            end
         end
      end
   end

   // Fetch qualification is registered alongside the RAM read so the hit
   // flag lines up with the word it gates. Indices at or beyond DEPTH can
   // never be below ProgLen, so truncating the RAM address never aliases.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_fetchHit <= 1'b0;
         r_progEnd  <= 1'b0;
         r_addrErr  <= 1'b0;
      end else begin
         r_fetchHit <= (r_state == RUN) && (w_idxExt < w_lenExt);
         r_progEnd  <= (r_state == RUN) && (w_idxExt == w_lenExt);
         r_addrErr  <= (i_instrAddr[1:0] != 2'b00);
      end
   end

   instr_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .i_clock  (i_clock),
      .i_wrEn   (w_wrEn),
      .i_wrAddr (r_progLen[AW-1:0]),
      .i_wrData (w_wordNext),
      .i_rdAddr (w_idx[AW-1:0]),
      .o_rdData (w_ramData)
   );

   assign o_loadReady = w_loadReady;
   assign o_loadDone  = w_loadDone;
   assign o_loadOvf   = r_loadOvf;
   assign o_progLen   = r_progLen;
   assign o_instrData = r_fetchHit ? w_ramData : NOP_WORD;
   assign o_progEnd   = r_progEnd;
   assign o_addrErr   = r_addrErr;

endmodule

// File: doc/instr_rom_loader.md
Name: instr_rom_loader

Overview:
- Synthesizable instruction memory that answers the processor's fetch port (InstrAddr in, instruction word out).
- Replaces the behavioural instruction feed in the benches.
- A byte-serial valid/ready load port fills the memory. Fetches then return the stored words, or NOP beyond the loaded length.
- Flags the end of the program so a bench or host can stop the run and check registers.

Parameters:
- ADDR_W, 16, width of InstrAddr (byte address).
- DEPTH, 256, number of 32-bit words; power of two.
- CNT_W, $clog2(DEPTH)+1, width of ProgLen.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- LoadStart  in  1  single-cycle pulse; in RUN, abandon the program and return to IDLE.
- LoadValid  in  1  load byte valid.
- LoadData  in  8  load byte; big-endian within each word.
- LoadLast  in  1  qualifies the final byte of the program.
- LoadReady  out  1  block accepts a byte this cycle.
- LoadDone  out  1  high while in RUN.
- LoadOvf  out  1  sticky; load exceeded DEPTH words.
- ProgLen  out  CNT_W  number of words loaded.
- InstrAddr  in  ADDR_W  fetch byte address.
- InstrData  out  32  fetched instruction word.
- ProgEnd  out  1  fetch word index equals ProgLen.
- AddrErr  out  1  fetch address not word aligned.

Behaviour:
- Reset values: state IDLE; InstrData 0; ProgLen 0; byte counter 0; LoadOvf, ProgEnd, AddrErr, LoadDone all 0. Memory contents are not reset.
- States:
  - IDLE: LoadReady=1, LoadDone=0. A handshake (LoadValid & LoadReady) moves to LOAD.
  - LOAD: LoadReady=1.
  - RUN: LoadReady=0, LoadDone=1.
- Byte assembly: a 2-bit byte counter selects the lane.
  - Byte 0 goes to [31:24], byte 3 to [7:0].
  - On the 4th byte, the word is written to mem[ProgLen] and ProgLen increments, both in the same cycle.
- LoadLast on an accepted byte:
  - Unfilled lower lanes are zero-padded.
  - If the word is partial, it is written and ProgLen increments.
  - Next state is RUN.
- LoadLast on byte 3 writes one word only; no extra empty word is written.
- Overflow:
  - When ProgLen==DEPTH and another byte is accepted, the byte is discarded, LoadOvf is set and the state moves to RUN.
  - LoadReady stays 1 up to that point so that the overflow is detectable.
- LoadValid while LoadReady=0 is ignored; there is no back-pressure in IDLE or LOAD.
- LoadStart:
  - In RUN: next state IDLE; ProgLen, LoadOvf and the byte counter are cleared.
  - In IDLE or LOAD: ignored.
  - Asserted together with LoadValid in RUN: the byte is not accepted.
- Fetch latency is 1 cycle, registered. With idx = InstrAddr[ADDR_W-1:2], at each posedge:
  - In RUN and idx < ProgLen: InstrData <= mem[idx].
  - Otherwise: InstrData <= 0 (NOP).
  - In IDLE or LOAD: InstrData = 0 always.
- ProgEnd: registered, same timing as InstrData. 1 iff RUN and idx == ProgLen; InstrData is 0 in that cycle.
- AddrErr: registered. 1 iff InstrAddr[1:0] != 0; the fetch still uses idx.
- Wrap-around: idx ≥ DEPTH always reads 0 because ProgLen ≤ DEPTH; there is no aliasing.
- Reset mid-load: asynchronous return to IDLE; the partial word is discarded.

Decomposition:
- Shared package instr_mem_pkg:
  - typedef load_state_e {IDLE, LOAD, RUN};
  - localparam NOP_WORD = 32'h0;
  - localparam WORD_BYTES = 4.
- One sub-module: instr_ram, a single-port-write/single-port-read synchronous RAM (DEPTH×32) with registered read. The loader FSM and fetch-qualification logic stay in the top module.

Test Plan:
- Load bytes 3C 01 12 34 34 21 56 78 with LoadLast on the 8th byte -> ProgLen=2, LoadDone=1. Fetch 0x0 -> 32'h3C011234 one cycle later; fetch 0x4 -> 32'h34215678.
- Continuing from the previous test, fetch 0x8 -> InstrData=0, ProgEnd=1. Fetch 0xC -> InstrData=0, ProgEnd=0.
- Load 5 bytes 00 41 18 20 AB with LoadLast on AB -> ProgLen=2, mem[1]=32'hAB000000.
- Fetch 0x2 after a 2-word load -> AddrErr=1, InstrData=mem[0]. Fetch during LOAD -> 0.
- DEPTH=4: stream 17 bytes without LoadLast -> LoadOvf=1, ProgLen=4, RUN entered. Then pulse LoadStart -> IDLE, ProgLen=0, LoadOvf=0.
- Assert Reset after 2 bytes of a load -> all outputs at reset values, LoadReady=1. A new 4-byte load then writes mem[0].
